phase_timer: RTL

PHASE_TIMER -- requirements
Module: phase_timer

---
 rtl/phase_timer_if.sv | 23 ++
 rtl/phase_timer.sv | 85 ++++++++
 2 files changed

// File: rtl/phase_timer_if.sv
// phase_timer_if: control and status bundle between a timer user and phase_timer
interface phase_timer_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 start;
  logic                 pause;
  logic                 abort;
  logic                 auto_reload;
  logic [CNT_WIDTH-1:0] load_value;
  logic [CNT_WIDTH-1:0] count;
  logic                 busy;
  logic                 expired;
  logic                 tick;
  logic                 done;
  modport master (
    output start, pause, abort, auto_reload, load_value,
    input  count, busy, expired, tick, done
  );
  modport slave (
    input  start, pause, abort, auto_reload, load_value,
    output count, busy, expired, tick, done
  );
endinterface

// File: rtl/phase_timer.sv
// phase_timer: prescaled countdown timer with pause, abort and optional auto-reload
module phase_timer #(
  parameter int CNT_WIDTH      = 8,
  parameter int TICKS_PER_UNIT = 1000
) (
  input logic          clk,
  input logic          reset,
  phase_timer_if.slave bus
);
  localparam int PW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam logic [PW-1:0] PSC_MAX = PW'(TICKS_PER_UNIT - 1);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;
  state_t               state, state_nxt;
  logic [PW-1:0]        psc, psc_nxt;
  logic [CNT_WIDTH-1:0] latched, latched_nxt, cnt_nxt;
  logic                 mode, mode_nxt;
  logic                 tick_nxt, done_nxt, busy_nxt, expired_nxt;
  logic                 active, wrap, last;
  assign active = (state == RUN) || (state == PAUSED);
  assign wrap   = psc == PSC_MAX;
  assign last   = bus.count <= CNT_WIDTH'(1);
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      psc     <= '0;
      latched <= '0;
      mode    <= 1'b0;
    end else begin
      state   <= state_nxt;
      psc     <= psc_nxt;
      latched <= latched_nxt;
      mode    <= mode_nxt;
    end
  // next state: abort beats start beats pause; PAUSED with pause low counts like RUN so no extra cycle is lost on resume
  always_comb begin
    state_nxt   = state;
    psc_nxt     = psc;
    cnt_nxt     = bus.count;
    latched_nxt = latched;
    mode_nxt    = mode;
    tick_nxt    = 1'b0;
    done_nxt    = 1'b0;
    if (bus.abort) begin
      state_nxt = IDLE;
      psc_nxt   = '0;
      cnt_nxt   = '0;
    end else if (bus.start) begin
      psc_nxt     = '0;
      cnt_nxt     = bus.load_value;
      latched_nxt = bus.load_value;
      mode_nxt    = bus.auto_reload;
      done_nxt    = bus.load_value == '0;
      state_nxt   = (bus.load_value == '0) ? EXPIRED : RUN;
    end else if (active && bus.pause) begin
      state_nxt = PAUSED;
    end else if (active) begin
      psc_nxt   = wrap ? '0 : psc + 1'b1;
      tick_nxt  = wrap;
      done_nxt  = wrap && last;
      cnt_nxt   = !wrap ? bus.count : !last ? bus.count - 1'b1 : mode ? latched : '0;
      state_nxt = (wrap && last && !mode) ? EXPIRED : RUN;
    end
  end
  // status flags follow the state being entered
  always_comb begin
    busy_nxt    = (state_nxt == RUN) || (state_nxt == PAUSED);
    expired_nxt = state_nxt == EXPIRED;
  end
  // registered outputs
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bus.count   <= '0;
      bus.busy    <= 1'b0;
      bus.expired <= 1'b0;
      bus.tick    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      bus.count   <= cnt_nxt;
      bus.busy    <= busy_nxt;
      bus.expired <= expired_nxt;
      bus.tick    <= tick_nxt;
      bus.done    <= done_nxt;
    end
endmodule
